// File: rtl/ycocg2rgb_arb_pipe.sv
// Two-source round-robin front end feeding a shared 2-stage YCoCg->RGB converter
// with per-pixel bypass, source tagging and per-source end-of-line flags.
module ycocg2rgb_arb_pipe #(
  parameter int BPC  = 8,
  parameter int LW_W = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LW_W-1:0]        line_width,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_csc_en,
  input  logic [2*BPC-1:0]       req_y,
  input  logic [2*(BPC+1)-1:0]   req_co,
  input  logic [2*(BPC+1)-1:0]   req_cg,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BPC-1:0]         out_r,
  output logic [BPC-1:0]         out_g,
  output logic [BPC-1:0]         out_b,
  output logic                   out_src,
  output logic                   out_eol,
  output logic                   busy
);

  localparam int CW = BPC + 2;
  localparam logic signed [CW-1:0] MAXV = CW'((1 << BPC) - 1);

  logic            rr_ptr;
  logic [1:0]      grant;
  logic            sel;
  logic            accept;
  logic            en1;
  logic            en2;

  logic            s1_valid;
  logic [BPC-1:0]  s1_y;
  logic [BPC:0]    s1_co;
  logic [BPC:0]    s1_cg;
  logic            s1_csc;
  logic            s1_src;
  logic            s1_eol;
  logic            s2_valid;

  logic [BPC-1:0]  sel_y;
  logic [BPC:0]    sel_co;
  logic [BPC:0]    sel_cg;
  logic            sel_csc;
  logic            sel_eol;

  logic [LW_W-1:0] cnt [2];
  logic [LW_W-1:0] lw_last;

  logic signed [CW-1:0] cy, cco, ccg, ct, cg_s, cb_s, cr_s;
  logic [BPC-1:0]  conv_r;
  logic [BPC-1:0]  conv_g;
  logic [BPC-1:0]  conv_b;

  function automatic logic [BPC-1:0] clamp(input logic signed [CW-1:0] v);
    if (v[CW-1])
      return '0;
    else if (v > MAXV)
      return '1;
    else
      return v[BPC-1:0];
  endfunction

  // With both requesters valid, the pointer names the source that waited last time.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign sel       = grant[1];
  assign en2       = !s2_valid | out_ready;
  assign en1       = !s1_valid | en2;
  assign req_ready = rst ? 2'b00 : (grant & {2{en1}});
  assign accept    = |req_ready;

  assign sel_y   = sel ? req_y[2*BPC-1:BPC]           : req_y[BPC-1:0];
  assign sel_co  = sel ? req_co[2*(BPC+1)-1:BPC+1]    : req_co[BPC:0];
  assign sel_cg  = sel ? req_cg[2*(BPC+1)-1:BPC+1]    : req_cg[BPC:0];
  assign sel_csc = sel ? req_csc_en[1]                : req_csc_en[0];

  // A zero line width behaves like one, so every pixel ends its line.
  assign lw_last = (line_width == '0) ? '0 : (line_width - 1'b1);
  assign sel_eol = (cnt[sel] == lw_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_y     <= '0;
      s1_co    <= '0;
      s1_cg    <= '0;
      s1_csc   <= 1'b0;
      s1_src   <= 1'b0;
      s1_eol   <= 1'b0;
      rr_ptr   <= 1'b0;
      cnt[0]   <= '0;
      cnt[1]   <= '0;
    end else begin
      if (en1)
        s1_valid <= accept;
      if (accept) begin
        s1_y     <= sel_y;
        s1_co    <= sel_co;
        s1_cg    <= sel_cg;
        s1_csc   <= sel_csc;
        s1_src   <= sel;
        s1_eol   <= sel_eol;
        rr_ptr   <= ~sel;
        cnt[sel] <= sel_eol ? '0 : (cnt[sel] + 1'b1);
      end
    end
  end

  // Lifting scheme evaluated in BPC+2 signed bits before clamping.
  always_comb begin
    cy   = $signed({2'b00, s1_y});
    cco  = $signed({s1_co[BPC], s1_co});
    ccg  = $signed({s1_cg[BPC], s1_cg});
    ct   = cy - (ccg >>> 1);
    cg_s = ccg + ct;
    cb_s = ct - (cco >>> 1);
    cr_s = cb_s + cco;
    if (s1_csc) begin
      conv_r = clamp(cr_s);
      conv_g = clamp(cg_s);
      conv_b = clamp(cb_s);
    end else begin
      conv_r = s1_cg[BPC-1:0];
      conv_g = s1_y;
      conv_b = s1_co[BPC-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_r    <= '0;
      out_g    <= '0;
      out_b    <= '0;
      out_src  <= 1'b0;
      out_eol  <= 1'b0;
    end else if (en2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_r   <= conv_r;
        out_g   <= conv_g;
        out_b   <= conv_b;
        out_src <= s1_src;
        out_eol <= s1_eol;
      end
    end
  end

  assign out_valid = s2_valid;
  assign busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_ycocg2rgb_arb_pipe.sv
// Directed bench for ycocg2rgb_arb_pipe: per-source request queues drive the DUT,
// a scoreboard of expected pixels is filled on accept and drained on output.
module tb_ycocg2rgb_arb_pipe;

  localparam int BPC  = 8;
  localparam int LW_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [LW_W-1:0]   line_width;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_csc_en;
  logic [2*BPC-1:0]  req_y;
  logic [17:0]       req_co;
  logic [17:0]       req_cg;
  logic              out_valid;
  logic              out_ready;
  logic [BPC-1:0]    out_r;
  logic [BPC-1:0]    out_g;
  logic [BPC-1:0]    out_b;
  logic              out_src;
  logic              out_eol;
  logic              busy;

  ycocg2rgb_arb_pipe #(.BPC(BPC), .LW_W(LW_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .line_width (line_width),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_csc_en (req_csc_en),
    .req_y      (req_y),
    .req_co     (req_co),
    .req_cg     (req_cg),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_r      (out_r),
    .out_g      (out_g),
    .out_b      (out_b),
    .out_src    (out_src),
    .out_eol    (out_eol),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] y;
    logic [8:0] co;
    logic [8:0] cg;
    logic       csc;
  } pix_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       src;
    logic       eol;
  } exp_t;

  pix_t q0[$];
  pix_t q1[$];
  exp_t sb[$];
  logic acc_log[$];
  int   acc_cyc[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   tb_cnt[2];
  int   lw;
  int   stall_lo;
  int   stall_hi;
  int   last_out_cyc;
  int   n_out;
  int   out_idx[2];
  logic [7:0] eol_mask[2];
  logic [7:0] last_r, last_g, last_b;
  logic last_src;
  logic last_acc_src;
  logic saw_block;
  logic first_src;

  function automatic pix_t mk(input int y, input int co, input int cg, input logic csc);
    pix_t p;
    p.y   = 8'(y);
    p.co  = 9'(co);
    p.cg  = 9'(cg);
    p.csc = csc;
    return p;
  endfunction

  function automatic logic [7:0] clamp8(input logic signed [9:0] v);
    if (v < 0) return 8'd0;
    if (v > 10'sd255) return 8'hff;
    return v[7:0];
  endfunction

  function automatic exp_t model(input pix_t p, input logic s, input logic e);
    logic signed [9:0] y, co, cg, t, g, b, r;
    exp_t x;
    y  = $signed({2'b00, p.y});
    co = $signed({p.co[8], p.co});
    cg = $signed({p.cg[8], p.cg});
    t  = y - (cg >>> 1);
    g  = cg + t;
    b  = t - (co >>> 1);
    r  = b + co;
    if (p.csc) begin
      x.r = clamp8(r);
      x.g = clamp8(g);
      x.b = clamp8(b);
    end else begin
      x.r = p.cg[7:0];
      x.g = p.y;
      x.b = p.co[7:0];
    end
    x.src = s;
    x.eol = e;
    return x;
  endfunction

  task automatic applyStimulus();
    pix_t p0, p1;
    p0 = (q0.size() > 0) ? q0[0] : '0;
    p1 = (q1.size() > 0) ? q1[0] : '0;
    req_valid  = {q1.size() > 0, q0.size() > 0};
    req_y      = {p1.y, p0.y};
    req_co     = {p1.co, p0.co};
    req_cg     = {p1.cg, p0.cg};
    req_csc_en = {p1.csc, p0.csc};
    out_ready  = !(cyc >= stall_lo && cyc <= stall_hi);
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    exp_t o;
    o = '{r: out_r, g: out_g, b: out_b, src: out_src, eol: out_eol};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("[TB] FAIL sb_pixel observed r=%0d g=%0d b=%0d src=%0d eol=%0d expected r=%0d g=%0d b=%0d src=%0d eol=%0d",
             o.r, o.g, o.b, o.src, o.eol, e.r, e.g, e.b, e.src, e.eol);
    end
  endtask

  task automatic push_expected(input logic s, input pix_t p);
    int   lw_eff;
    logic e;
    lw_eff = (lw == 0) ? 1 : lw;
    e = (tb_cnt[s] == lw_eff - 1);
    tb_cnt[s] = e ? 0 : tb_cnt[s] + 1;
    sb.push_back(model(p, s, e));
    acc_log.push_back(s);
    acc_cyc.push_back(cyc);
    last_acc_src = s;
  endtask

  task automatic step();
    exp_t e;
    applyStimulus();
    @(negedge clk);
    check("ready_onehot", int'($onehot0(req_ready)), 1);
    if (req_valid[0] && !req_ready[0] && !out_ready) saw_block = 1'b1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_output", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput(e);
        last_r = out_r;
        last_g = out_g;
        last_b = out_b;
        last_src = out_src;
        last_out_cyc = cyc;
        n_out++;
        if (out_idx[out_src] < 8 && out_eol)
          eol_mask[out_src][out_idx[out_src]] = 1'b1;
        out_idx[out_src]++;
      end
    end
    if (req_valid[0] && req_ready[0]) begin
      push_expected(1'b0, q0[0]);
      void'(q0.pop_front());
    end
    if (req_valid[1] && req_ready[1]) begin
      push_expected(1'b1, q1[0]);
      void'(q1.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && n < 300) begin
      step();
      n++;
    end
    check("drain_bound", int'(n < 300), 1);
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    applyStimulus();
    repeat (ncyc) @(posedge clk);
    #1;
    tb_cnt[0] = 0;
    tb_cnt[1] = 0;
    sb.delete();
  endtask

  task automatic single(input pix_t p, input int er, input int eg, input int eb, input string tag);
    q0.push_back(p);
    drain();
    check({tag, "_r"}, last_r, er);
    check({tag, "_g"}, last_g, eg);
    check({tag, "_b"}, last_b, eb);
    check({tag, "_src"}, last_src, 0);
    check({tag, "_latency"}, last_out_cyc - acc_cyc[$], 2);
  endtask

  initial begin
    stall_lo = -10;
    stall_hi = -20;
    lw = 16;
    line_width = LW_W'(lw);
    n_out = 0;
    out_idx[0] = 0;
    out_idx[1] = 0;
    eol_mask[0] = '0;
    eol_mask[1] = '0;
    saw_block = 1'b0;
    last_acc_src = 1'b1;
    last_r = '0; last_g = '0; last_b = '0; last_src = 1'b0;
    last_out_cyc = 0;

    // Reset held with both requesters valid
    q0.push_back(mk(40, 3, -6, 1'b1));
    q1.push_back(mk(50, -7, 9, 1'b1));
    do_reset(2);
    check("rst_req_ready", req_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_g", out_g, 0);
    check("rst_out_b", out_b, 0);
    check("rst_out_src", out_src, 0);
    check("rst_out_eol", out_eol, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    acc_log.delete();
    step();
    check("first_grant_count", acc_log.size(), 1);
    check("first_grant_src", int'(acc_log[0]), 0);
    drain();
    check("idle_busy", busy, 0);

    // Colour conversion and clamping, then bypass
    single(mk(128, 0, 0, 1'b1), 128, 128, 128, "csc_grey");
    single(mk(255, 255, 0, 1'b1), 255, 255, 128, "csc_rclamp");
    single(mk(0, 0, -256, 1'b1), 128, 0, 128, "csc_gclamp");
    single(mk(10, 20, 30, 1'b0), 30, 10, 20, "bypass");

    // Both sources continuously valid: strict alternation at one accept per cycle
    acc_log.delete();
    acc_cyc.delete();
    first_src = ~last_acc_src;
    for (int k = 0; k < 6; k++) begin
      q0.push_back(mk($urandom_range(255), $urandom_range(511), $urandom_range(511), 1'b1));
      q1.push_back(mk($urandom_range(255), $urandom_range(511), $urandom_range(511), 1'b1));
    end
    drain();
    for (int k = 0; k < 12; k++) begin
      check("rr_order", int'(acc_log[k]), int'(first_src ^ k[0]));
      check("rr_rate", acc_cyc[k] - acc_cyc[0], k);
    end

    // Only source 1 valid
    acc_log.delete();
    acc_cyc.delete();
    for (int k = 0; k < 4; k++)
      q1.push_back(mk($urandom_range(255), $urandom_range(511), $urandom_range(511), 1'(k)));
    drain();
    for (int k = 0; k < 4; k++) begin
      check("solo_src", int'(acc_log[k]), 1);
      check("solo_rate", acc_cyc[k] - acc_cyc[0], k);
    end

    // Backpressure window on a 20-pixel stream
    saw_block = 1'b0;
    n_out = 0;
    stall_lo = cyc + 5;
    stall_hi = cyc + 9;
    for (int k = 0; k < 20; k++)
      q0.push_back(mk($urandom_range(255), $urandom_range(511), $urandom_range(511), 1'($urandom_range(1))));
    drain();
    check("bp_blocked", saw_block, 1);
    check("bp_count", n_out, 20);
    check("bp_idle", busy, 0);

    // End-of-line flags, line width 4, interleaved sources
    lw = 4;
    line_width = LW_W'(lw);
    do_reset(1);
    rst = 1'b0;
    out_idx[0] = 0; out_idx[1] = 0;
    eol_mask[0] = '0; eol_mask[1] = '0;
    for (int k = 0; k < 8; k++) begin
      q0.push_back(mk(k, 0, 0, 1'b1));
      q1.push_back(mk(k + 100, 0, 0, 1'b0));
    end
    drain();
    check("eol_lw4_src0", eol_mask[0], 8'h88);
    check("eol_lw4_src1", eol_mask[1], 8'h88);

    // Line width 0 flags every pixel
    lw = 0;
    line_width = '0;
    out_idx[0] = 0; out_idx[1] = 0;
    eol_mask[0] = '0; eol_mask[1] = '0;
    for (int k = 0; k < 5; k++) q0.push_back(mk(k, 1, 1, 1'b1));
    for (int k = 0; k < 3; k++) q1.push_back(mk(k, 2, 2, 1'b1));
    drain();
    check("eol_lw0_src0", eol_mask[0], 8'h1f);
    check("eol_lw0_src1", eol_mask[1], 8'h07);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
